// File: rtl/button_gesture_pkg.sv
// Shared timing constants for the button front end (debouncer and gesture decoder).
// Every cycle count is derived from the single system clock frequency.
package button_gesture_pkg;

  localparam int CLK_HZ              = 25_000_000;
  localparam int DEFAULT_LONG_CLKS   = CLK_HZ / 2;   // 500 ms
  localparam int DEFAULT_GAP_CLKS    = CLK_HZ / 4;   // 250 ms
  localparam int DEFAULT_REPEAT_CLKS = CLK_HZ / 10;  // 100 ms

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/button_gesture_edge_detect.sv
// Edge detector for a synchronous level: combinational rise/fall for same-cycle
// decisions, plus registered rise/fall pulses and a registered copy of the level.
module button_gesture_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall,
  output logic rise_q,
  output logic fall_q,
  output logic level
);

  logic r_prev;

  assign rise  = din & ~r_prev;
  assign fall  = ~din & r_prev;
  assign level = r_prev;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      r_prev <= din;
      rise_q <= rise;
      fall_q <= fall;
    end
  end

endmodule

// File: rtl/button_gesture.sv
// Button gesture decoder: turns a debounced level into press/release/single/
// double/long/repeat pulses plus a held level, using one shared cycle counter.
module button_gesture
  import button_gesture_pkg::*;
#(
  parameter int LONG_CLKS   = DEFAULT_LONG_CLKS,
  parameter int GAP_CLKS    = DEFAULT_GAP_CLKS,
  parameter int REPEAT_CLKS = DEFAULT_REPEAT_CLKS
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clean,
  output logic o_press,
  output logic o_release,
  output logic o_single,
  output logic o_double,
  output logic o_long,
  output logic o_repeat,
  output logic o_held
);

  localparam int CNT_W = $clog2(max3(LONG_CLKS, GAP_CLKS, REPEAT_CLKS));
  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CLKS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CLKS - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CLKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS1,
    S_WAIT2,
    S_PRESS2,
    S_LONG
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] r_cnt;
  logic             rise;
  logic             fall;

  button_gesture_edge_detect u_edge (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .din    (i_clean),
    .rise   (rise),
    .fall   (fall),
    .rise_q (o_press),
    .fall_q (o_release),
    .level  (o_held)
  );

  // The counter only runs in timed states, so it never wraps: every compare
  // value is reached before the count could overflow.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= S_IDLE;
      r_cnt    <= '0;
      o_single <= 1'b0;
      o_double <= 1'b0;
      o_long   <= 1'b0;
      o_repeat <= 1'b0;
    end else begin
      o_single <= 1'b0;
      o_double <= 1'b0;
      o_long   <= 1'b0;
      o_repeat <= 1'b0;
      case (state)
        S_IDLE: begin
          r_cnt <= '0;
          if (rise) state <= S_PRESS1;
        end
        S_PRESS1: begin
          if (fall) begin
            state <= S_WAIT2;
            r_cnt <= '0;
          end else if (r_cnt == LONG_LAST) begin
            o_long <= 1'b1;
            state  <= S_LONG;
            r_cnt  <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WAIT2: begin
          // A rise on the timeout cycle still counts as a double click.
          if (rise) begin
            o_double <= 1'b1;
            state    <= S_PRESS2;
            r_cnt    <= '0;
          end else if (r_cnt == GAP_LAST) begin
            o_single <= 1'b1;
            state    <= S_IDLE;
            r_cnt    <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_PRESS2: begin
          r_cnt <= '0;
          if (fall) state <= S_IDLE;
        end
        S_LONG: begin
          // Release wins over a coincident repeat tick.
          if (fall) begin
            state <= S_IDLE;
            r_cnt <= '0;
          end else if (r_cnt == REPEAT_LAST) begin
            o_repeat <= 1'b1;
            r_cnt    <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          r_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_gesture.sv
// Self-checking bench for button_gesture with short timings (LONG=20, GAP=10,
// REPEAT=5): a per-cycle vector table plus hand-written reset sequences.
module tb_button_gesture;

  localparam logic [6:0] B_PRESS  = 7'b1000000;
  localparam logic [6:0] B_REL    = 7'b0100000;
  localparam logic [6:0] B_SINGLE = 7'b0010000;
  localparam logic [6:0] B_DOUBLE = 7'b0001000;
  localparam logic [6:0] B_LONG   = 7'b0000100;
  localparam logic [6:0] B_REPEAT = 7'b0000010;
  localparam logic [6:0] B_HELD   = 7'b0000001;
  localparam logic [6:0] B_NONE   = 7'b0000000;

  typedef struct {
    logic       clean;
    logic [6:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic i_clean;
  logic o_press, o_release, o_single, o_double, o_long, o_repeat, o_held;

  int   n_vec = 0;
  int   n_err = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  button_gesture #(
    .LONG_CLKS   (20),
    .GAP_CLKS    (10),
    .REPEAT_CLKS (5)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_clean   (i_clean),
    .o_press   (o_press),
    .o_release (o_release),
    .o_single  (o_single),
    .o_double  (o_double),
    .o_long    (o_long),
    .o_repeat  (o_repeat),
    .o_held    (o_held)
  );

  function automatic logic [6:0] outs();
    return {o_press, o_release, o_single, o_double, o_long, o_repeat, o_held};
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got press/rel/single/double/long/repeat/held=%b, want %b",
               name, act, exp);
    end
  endtask

  // Drive one cycle of input, let the DUT clock it, compare on the falling edge.
  task automatic step(input logic clean, input logic [6:0] exp, input string name);
    i_clean = clean;
    @(posedge clk);
    @(negedge clk);
    check(name, outs(), exp);
  endtask

  function automatic int add(input logic clean, input int n);
    int start;
    start = vecs.size();
    for (int i = 0; i < n; i++) vecs.push_back('{clean, clean ? B_HELD : B_NONE});
    return start;
  endfunction

  function automatic void mark(input int idx, input logic [6:0] bits);
    vecs[idx].exp = vecs[idx].exp | bits;
  endfunction

  initial begin
    int p, r, p2, r2;

    // Idle after reset: nothing at all.
    void'(add(0, 50));

    // Single click: press 5, release; single 10 cycles after the release pulse.
    p = add(1, 5);  mark(p, B_PRESS);
    r = add(0, 15); mark(r, B_REL); mark(r + 10, B_SINGLE);

    // Double click: second press 4 cycles into the gap.
    p  = add(1, 5);  mark(p, B_PRESS);
    r  = add(0, 4);  mark(r, B_REL);
    p2 = add(1, 5);  mark(p2, B_PRESS | B_DOUBLE);
    r2 = add(0, 20); mark(r2, B_REL);

    // Long press held 37 cycles: long at 20, repeats at 25/30/35.
    p = add(1, 37);
    mark(p, B_PRESS); mark(p + 20, B_LONG);
    mark(p + 25, B_REPEAT); mark(p + 30, B_REPEAT); mark(p + 35, B_REPEAT);
    r = add(0, 15); mark(r, B_REL);

    // Hold 30: release lands on a repeat tick, so no repeat there.
    p = add(1, 30);
    mark(p, B_PRESS); mark(p + 20, B_LONG); mark(p + 25, B_REPEAT);
    r = add(0, 3); mark(r, B_REL);

    // Second press exactly on the gap timeout cycle is a double.
    p  = add(1, 2);  mark(p, B_PRESS);
    r  = add(0, 10); mark(r, B_REL);
    p2 = add(1, 3);  mark(p2, B_PRESS | B_DOUBLE);
    r2 = add(0, 15); mark(r2, B_REL);

    // One-cycle pulse on the input behaves as a full click.
    p = add(1, 1);  mark(p, B_PRESS);
    r = add(0, 15); mark(r, B_REL); mark(r + 10, B_SINGLE);

    // Reset held with input low.
    rst_n   = 1'b0;
    i_clean = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, B_NONE, "reset_low");
    rst_n = 1'b1;

    foreach (vecs[i]) step(vecs[i].clean, vecs[i].exp, $sformatf("vec%0d", i));

    // Asynchronous clear while held, then button held through reset.
    step(1'b1, B_PRESS | B_HELD, "pre_reset_press");
    step(1'b1, B_HELD, "pre_reset_hold");
    #2 rst_n = 1'b0;
    #1 check("async_clear", outs(), B_NONE);
    step(1'b1, B_NONE, "reset_held_0");
    step(1'b1, B_NONE, "reset_held_1");
    rst_n = 1'b1;
    step(1'b1, B_PRESS | B_HELD, "press_after_reset");
    for (int i = 0; i < 3; i++) step(1'b1, B_HELD, "hold_after_reset");
    step(1'b0, B_REL, "release_after_reset");
    for (int i = 0; i < 3; i++) step(1'b0, B_NONE, "in_wait2");

    // Reset in the middle of the gap: the pending single is abandoned.
    #2 rst_n = 1'b0;
    #1 check("async_clear_wait2", outs(), B_NONE);
    step(1'b0, B_NONE, "reset_wait2");
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) step(1'b0, B_NONE, "no_single_after_reset");

    // FSM is back in IDLE: a fresh click behaves normally.
    step(1'b1, B_PRESS | B_HELD, "click_press");
    step(1'b0, B_REL, "click_release");
    for (int i = 0; i < 9; i++) step(1'b0, B_NONE, "click_gap");
    step(1'b0, B_SINGLE, "click_single");
    step(1'b0, B_NONE, "click_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
